// File: rtl/fft_top.sv
// fft_top
// Radix-2 decimation-in-time FFT engine with an in-place register memory.
// A start pulse loads N complex samples serially (stored bit-reversed).
// The core then runs L_max stages of N/2 butterflies, one per clock.
// Afterwards it raises fft_finish and serves bins in natural order.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   initial_en  one-cycle start/load pulse, accepted in any state
//   datain_re   signed real part of the streamed input sample
//   datain_im   signed imaginary part of the streamed input sample
//   read_addr   result bin index
//   dataout_re  registered real part of bin read_addr (0 unless done)
//   dataout_im  registered imaginary part of bin read_addr (0 unless done)
//   fft_finish  high while the memory holds valid results
module fft_top #(
   parameter int N     = 512,
   parameter int L_max = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    initial_en,
   input  logic signed [23:0]      datain_re,
   input  logic signed [23:0]      datain_im,
   input  logic [L_max-1:0]        read_addr,
   output logic signed [23:0]      dataout_re,
   output logic signed [23:0]      dataout_im,
   output logic                    fft_finish
);

   localparam int  SW = $clog2(L_max + 1);
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   state_t state, next_state;

   logic [47:0]            mem [N];
   logic [L_max-1:0]       load_cnt;
   logic [L_max-2:0]       bf_cnt;
   logic [SW-1:0]          stage;
   logic                   load_we;
   logic                   calc_en;
   logic                   last_bf;

   logic [L_max-2:0]       low_mask;
   logic [L_max-2:0]       p_in;
   logic [L_max-2:0]       hi_bits;
   logic [L_max-1:0]       addr_a;
   logic [L_max-1:0]       addr_b;
   logic [L_max-2:0]       tw_idx;

   logic signed [15:0]     tw_cos [N/2];
   logic signed [15:0]     tw_sin [N/2];

   logic [47:0]            word_a, word_b;
   logic signed [23:0]     a_re, a_im, b_re, b_im;
   logic signed [15:0]     w_c, w_s;
   logic signed [40:0]     pr_re, pr_im;
   logic signed [25:0]     t_re, t_im;
   logic signed [25:0]     sa_re, sa_im, sb_re, sb_im;
   logic [47:0]            new_a, new_b;

   function automatic logic [L_max-1:0] bitrev(input logic [L_max-1:0] v);
      logic [L_max-1:0] r;
      for (int i = 0; i < L_max; i++) r[i] = v[L_max-1-i];
      return r;
   endfunction

   // Twiddle ROM in Q2.14: entry j holds cos and sin of 2*pi*j/N, rounded.
   // The butterfly applies W_j = cos - i*sin.
   for (genvar j = 0; j < N/2; j++) begin : g_tw
      localparam real ANG   = 2.0 * PI * j / N;
      localparam int  COS_Q = $rtoi($floor(16384.0 * $cos(ANG) + 0.5));
      localparam int  SIN_Q = $rtoi($floor(16384.0 * $sin(ANG) + 0.5));
      assign tw_cos[j] = 16'(COS_Q);
      assign tw_sin[j] = 16'(SIN_Q);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // A start pulse overrides every other transition.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = IDLE;
         LOAD:    if (load_cnt == L_max'(N-1)) next_state = CALC;
         CALC:    if (last_bf) next_state = DONE;
         DONE:    next_state = DONE;
         default: next_state = IDLE;
      endcase
      if (initial_en) next_state = LOAD;
   end

   // The cycle that samples initial_en only restarts; it neither writes
   // a sample nor performs a butterfly.
   always_comb begin
      load_we = 1'b0;
      calc_en = 1'b0;
      if (!initial_en) begin
         load_we = (state == LOAD);
         calc_en = (state == CALC);
      end
   end

   assign last_bf = (stage == SW'(L_max-1)) && (&bf_cnt);

   always_ff @(posedge clk) begin
      if (rst || initial_en) begin
         load_cnt <= '0;
         bf_cnt   <= '0;
         stage    <= '0;
      end else begin
         if (load_we) load_cnt <= load_cnt + L_max'(1);
         if (calc_en) begin
            bf_cnt <= bf_cnt + (L_max-1)'(1);
            if (&bf_cnt) stage <= stage + SW'(1);
         end
      end
   end

   // Butterfly i of a stage with span h = 2^stage: the upper address is i
   // with a zero inserted at bit position "stage", the partner is +h, and
   // the twiddle index is (i mod h) scaled by N/(2h).
   always_comb begin
      low_mask = (L_max-1)'((L_max'(1) << stage) - L_max'(1));
      p_in     = bf_cnt & low_mask;
      hi_bits  = bf_cnt & ~low_mask;
      addr_a   = {hi_bits, 1'b0} | {1'b0, p_in};
      addr_b   = addr_a | (L_max'(1) << stage);
      tw_idx   = p_in << (SW'(L_max-1) - stage);
   end

   // t = (B*W) >>> 14 at full precision, then halved sum/difference in
   // 26 bits with floor truncation back to 24 bits.
   always_comb begin
      word_a = mem[addr_a];
      word_b = mem[addr_b];
      a_re   = word_a[47:24];
      a_im   = word_a[23:0];
      b_re   = word_b[47:24];
      b_im   = word_b[23:0];
      w_c    = tw_cos[tw_idx];
      w_s    = tw_sin[tw_idx];
      pr_re  = 41'(b_re) * 41'(w_c) + 41'(b_im) * 41'(w_s);
      pr_im  = 41'(b_im) * 41'(w_c) - 41'(b_re) * 41'(w_s);
      t_re   = 26'(pr_re >>> 14);
      t_im   = 26'(pr_im >>> 14);
      sa_re  = 26'(a_re) + t_re;
      sa_im  = 26'(a_im) + t_im;
      sb_re  = 26'(a_re) - t_re;
      sb_im  = 26'(a_im) - t_im;
      new_a  = {24'(sa_re >>> 1), 24'(sa_im >>> 1)};
      new_b  = {24'(sb_re >>> 1), 24'(sb_im >>> 1)};
   end

   // Memory contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[bitrev(load_cnt)] <= {datain_re, datain_im};
      end else if (calc_en) begin
         mem[addr_a] <= new_a;
         mem[addr_b] <= new_b;
      end
   end

   // fft_finish follows DONE by one clock, so it rises the edge after the
   // last butterfly and falls the edge after a restart is sampled.
   // dataout is qualified the same way and so is zero whenever
   // fft_finish is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         fft_finish <= 1'b0;
         dataout_re <= '0;
         dataout_im <= '0;
      end else begin
         fft_finish <= (state == DONE);
         if (state == DONE) begin
            dataout_re <= mem[read_addr][47:24];
            dataout_im <= mem[read_addr][23:0];
         end else begin
            dataout_re <= '0;
            dataout_im <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fft_top.sv
// tb_fft_top
// Self-checking bench for fft_top. Each feature is exercised by its own
// task with inline comparisons. Randomized vectors are checked against a
// direct 1/N-scaled DFT computed in real arithmetic.
module tb_fft_top;

   localparam int  N       = 512;
   localparam int  LM      = 9;
   localparam int  FIN_LAT = N + LM * N / 2 + 1;
   localparam real TOL     = 32.0;
   localparam real PI      = 3.14159265358979323846;

   logic                clk = 1'b0;
   logic                rst;
   logic                initial_en;
   logic signed [23:0]  datain_re;
   logic signed [23:0]  datain_im;
   logic [LM-1:0]       read_addr;
   logic signed [23:0]  dataout_re;
   logic signed [23:0]  dataout_im;
   logic                fft_finish;

   int  checks = 0;
   int  errors = 0;

   int  xin_re [N];
   int  xin_im [N];
   int  got_re [N];
   int  got_im [N];
   real mdl_re [N];
   real mdl_im [N];
   real ctab   [N];
   real stab   [N];

   fft_top #(.N(N), .L_max(LM)) dut (
      .clk        (clk),
      .rst        (rst),
      .initial_en (initial_en),
      .datain_re  (datain_re),
      .datain_im  (datain_im),
      .read_addr  (read_addr),
      .dataout_re (dataout_re),
      .dataout_im (dataout_im),
      .fft_finish (fft_finish)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start; sample k is presented so that it is captured at E+1+k.
   task automatic load_vector();
      initial_en = 1'b1;
      tick();
      initial_en = 1'b0;
      for (int k = 0; k < N; k++) begin
         datain_re = 24'(xin_re[k]);
         datain_im = 24'(xin_im[k]);
         tick();
      end
      datain_re = 24'($urandom);
      datain_im = 24'($urandom);
   endtask

   // Returns the number of edges from E until fft_finish is seen high.
   task automatic wait_finish(output int lat);
      lat = N;
      while (!fft_finish && lat < FIN_LAT + 200) begin
         datain_re = 24'($urandom);
         datain_im = 24'($urandom);
         tick();
         lat++;
      end
   endtask

   task automatic read_bins();
      for (int a = 0; a < N; a++) begin
         read_addr = LM'(a);
         tick();
         got_re[a] = dataout_re;
         got_im[a] = dataout_im;
      end
   endtask

   task automatic compute_model();
      for (int k = 0; k < N; k++) begin
         real sr, si;
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < N; n++) begin
            int idx;
            idx = (n * k) % N;
            sr = sr + xin_re[n] * ctab[idx] + xin_im[n] * stab[idx];
            si = si + xin_im[n] * ctab[idx] - xin_re[n] * stab[idx];
         end
         mdl_re[k] = sr / N;
         mdl_im[k] = si / N;
      end
   endtask

   task automatic random_vector();
      for (int n = 0; n < N; n++) begin
         xin_re[n] = int'($urandom_range(0, 1 << 19)) - (1 << 18);
         xin_im[n] = int'($urandom_range(0, 1 << 19)) - (1 << 18);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      initial_en = 1'b0;
      datain_re  = '0;
      datain_im  = '0;
      read_addr  = '0;
      repeat (3) tick();
      checks++;
      if (fft_finish !== 1'b0 || dataout_re !== 24'sd0 || dataout_im !== 24'sd0) begin
         errors++;
         $display("[TB] FAIL reset_values finish=%b re=%0d im=%0d required 0/0/0",
                  fft_finish, dataout_re, dataout_im);
      end
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (fft_finish !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_no_finish finish=%b required 0", fft_finish);
      end
   endtask

   task automatic test_impulse(input string tag);
      int lat;
      for (int n = 0; n < N; n++) begin
         xin_re[n] = 0;
         xin_im[n] = 0;
      end
      xin_re[0] = 1 << 20;
      load_vector();
      wait_finish(lat);
      checks++;
      if (lat !== FIN_LAT) begin
         errors++;
         $display("[TB] FAIL %s_latency finish after %0d edges required %0d", tag, lat, FIN_LAT);
      end
      read_bins();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (got_re[k] !== 2048 || got_im[k] !== 0) begin
            errors++;
            $display("[TB] FAIL %s_bin k=%0d got %0d,%0d required 2048,0", tag, k, got_re[k], got_im[k]);
         end
      end
   endtask

   task automatic check_dc_bins(input string tag);
      for (int k = 0; k < N; k++) begin
         int er;
         er = (k == 0) ? 4096 : 0;
         checks++;
         if (got_re[k] !== er || got_im[k] !== 0) begin
            errors++;
            $display("[TB] FAIL %s_bin k=%0d got %0d,%0d required %0d,0", tag, k, got_re[k], got_im[k], er);
         end
      end
   endtask

   task automatic test_dc();
      int lat;
      for (int n = 0; n < N; n++) begin
         xin_re[n] = 4096;
         xin_im[n] = 0;
      end
      load_vector();
      wait_finish(lat);
      checks++;
      if (lat !== FIN_LAT) begin
         errors++;
         $display("[TB] FAIL dc_latency finish after %0d edges required %0d", lat, FIN_LAT);
      end
      read_bins();
      check_dc_bins("dc");
   endtask

   task automatic test_cosine();
      int lat;
      for (int n = 0; n < N; n++) begin
         xin_re[n] = $rtoi($floor(1048576.0 * $cos(2.0 * PI * 8.0 * n / N) + 0.5));
         xin_im[n] = 0;
      end
      load_vector();
      wait_finish(lat);
      checks++;
      if (lat !== FIN_LAT) begin
         errors++;
         $display("[TB] FAIL cos_latency finish after %0d edges required %0d", lat, FIN_LAT);
      end
      read_bins();
      for (int k = 0; k < N; k++) begin
         int er, dr, di;
         er = (k == 8 || k == N - 8) ? 524288 : 0;
         dr = got_re[k] - er;
         di = got_im[k];
         checks++;
         if (dr > 64 || dr < -64 || di > 64 || di < -64) begin
            errors++;
            $display("[TB] FAIL cos_bin k=%0d got %0d,%0d required %0d,0 within 64",
                     k, got_re[k], got_im[k], er);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      random_vector();
      compute_model();
      load_vector();
      wait_finish(lat);
      checks++;
      if (lat !== FIN_LAT) begin
         errors++;
         $display("[TB] FAIL rand_latency finish after %0d edges required %0d", lat, FIN_LAT);
      end
      read_bins();
      for (int k = 0; k < N; k++) begin
         real dr, di;
         dr = got_re[k] - mdl_re[k];
         di = got_im[k] - mdl_im[k];
         checks++;
         if (dr > TOL || dr < -TOL || di > TOL || di < -TOL) begin
            errors++;
            $display("[TB] FAIL rand_bin k=%0d got %0d,%0d required %0.1f,%0.1f",
                     k, got_re[k], got_im[k], mdl_re[k], mdl_im[k]);
         end
      end
   endtask

   // Relies on the random results left in memory by test_random.
   task automatic test_readout_latency();
      int prev;
      prev = N - 1;
      for (int i = 0; i < 64; i++) begin
         int  a;
         real dr, di;
         a = $urandom_range(0, N - 1);
         read_addr = LM'(a);
         #1;
         dr = dataout_re - mdl_re[prev];
         di = dataout_im - mdl_im[prev];
         checks++;
         if (dr > TOL || dr < -TOL || di > TOL || di < -TOL) begin
            errors++;
            $display("[TB] FAIL readout_hold addr=%0d got %0d,%0d required %0.1f,%0.1f",
                     prev, dataout_re, dataout_im, mdl_re[prev], mdl_im[prev]);
         end
         tick();
         dr = dataout_re - mdl_re[a];
         di = dataout_im - mdl_im[a];
         checks++;
         if (fft_finish !== 1'b1 || dr > TOL || dr < -TOL || di > TOL || di < -TOL) begin
            errors++;
            $display("[TB] FAIL readout_next addr=%0d finish=%b got %0d,%0d required 1 %0.1f,%0.1f",
                     a, fft_finish, dataout_re, dataout_im, mdl_re[a], mdl_im[a]);
         end
         prev = a;
      end
   endtask

   task automatic test_reset_mid_calc();
      int seen;
      random_vector();
      load_vector();
      repeat (1000) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (fft_finish !== 1'b0 || dataout_re !== 24'sd0 || dataout_im !== 24'sd0) begin
         errors++;
         $display("[TB] FAIL midcalc_reset finish=%b re=%0d im=%0d required 0/0/0",
                  fft_finish, dataout_re, dataout_im);
      end
      rst  = 1'b0;
      seen = 0;
      repeat (3000) begin
         tick();
         if (fft_finish) seen = 1;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL midcalc_abort finish seen=%0d required 0", seen);
      end
      test_impulse("rerun");
   endtask

   task automatic test_restart_done();
      int lat;
      for (int n = 0; n < N; n++) begin
         xin_re[n] = 4096;
         xin_im[n] = 0;
      end
      initial_en = 1'b1;
      tick();
      initial_en = 1'b0;
      checks++;
      if (fft_finish !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_at_E finish=%b required 1", fft_finish);
      end
      for (int k = 0; k < N; k++) begin
         datain_re = 24'(xin_re[k]);
         datain_im = 24'(xin_im[k]);
         tick();
         if (k == 0) begin
            checks++;
            if (fft_finish !== 1'b0 || dataout_re !== 24'sd0 || dataout_im !== 24'sd0) begin
               errors++;
               $display("[TB] FAIL restart_drop finish=%b re=%0d im=%0d required 0/0/0",
                        fft_finish, dataout_re, dataout_im);
            end
         end
      end
      wait_finish(lat);
      checks++;
      if (lat !== FIN_LAT) begin
         errors++;
         $display("[TB] FAIL restart_latency finish after %0d edges required %0d", lat, FIN_LAT);
      end
      read_bins();
      check_dc_bins("restart");
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         ctab[i] = $cos(2.0 * PI * i / N);
         stab[i] = $sin(2.0 * PI * i / N);
      end
      test_reset();
      test_impulse("impulse");
      test_dc();
      test_cosine();
      test_random();
      test_readout_latency();
      test_reset_mid_calc();
      test_restart_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
